rst_generator: RTL and testbench



---
 rtl/rst_generator.sv | 201 ++++++++++++++++++++
 tb/tb_rst_generator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_generator.sv
`default_nettype none
// ============================================================================
// Module   : rst_generator
// Purpose  : Reset sequencer on the bus clock. It combines a debounced
//            push-button and the DCM lock indication into two ordered resets.
//            The bus reset is released first and the core reset CORE_DELAY
//            cycles later. A ready flag is raised once both are released.
// Ports    : clk_i        - bus clock
//            rst_i        - asynchronous active-high global reset
//            btn_rst_i    - raw push-button, active-high, asynchronous
//            dcm_locked_i - DCM LOCKED, asynchronous to clk_i
//            rst_bus_o    - registered reset for bus and peripherals
//            rst_core_o   - registered reset for the core
//            ready_o      - registered, high only when both resets released
// Revision : 1.0 - initial release
// ============================================================================
module rst_generator #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCK_CYCLES     = 16,
    parameter int HOLD_CYCLES     = 16,
    parameter int CORE_DELAY      = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_rst_i,
    input  logic dcm_locked_i,
    output logic rst_bus_o,
    output logic rst_core_o,
    output logic ready_o
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // One sequence counter is shared by WAIT_LOCK, HOLD and BUS_UP, since
    // only one of them is counting at any time.
    localparam int c_SEQ_MAX =
        (LOCK_CYCLES > HOLD_CYCLES)
            ? ((LOCK_CYCLES > CORE_DELAY) ? LOCK_CYCLES : CORE_DELAY)
            : ((HOLD_CYCLES > CORE_DELAY) ? HOLD_CYCLES : CORE_DELAY);
    localparam int c_SEQ_W = (c_SEQ_MAX > 1) ? $clog2(c_SEQ_MAX) : 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_SEQ_W-1:0] c_LOCK_LAST = c_SEQ_W'(LOCK_CYCLES - 1);
    localparam logic [c_SEQ_W-1:0] c_HOLD_LAST = c_SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [c_SEQ_W-1:0] c_CORE_LAST = c_SEQ_W'(CORE_DELAY - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLD      = 2'd1,
        S_BUS_UP    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous inputs
    // ------------------------------------------------------------------
    logic r_btn_meta;
    logic r_btn_sync;
    logic r_lock_meta;
    logic r_lock_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_btn_meta  <= btn_rst_i;
            r_btn_sync  <= r_btn_meta;
            r_lock_meta <= dcm_locked_i;
            r_lock_sync <= r_lock_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: the accepted level only flips after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    // ------------------------------------------------------------------
    logic               r_btn_stable;
    logic [c_DEB_W-1:0] r_deb_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_btn_stable <= 1'b0;
            r_deb_cnt    <= '0;
        end else if (r_btn_sync != r_btn_stable) begin
            if (r_deb_cnt == c_DEB_LAST) begin
                r_btn_stable <= ~r_btn_stable;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    // Lock is deliberately not debounced: losing it must reset quickly.
    logic w_abort;
    assign w_abort = r_btn_stable | ~r_lock_sync;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SEQ_W-1:0] r_cnt;
    logic [c_SEQ_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // abort is tested before every completion check so that it always wins
    // over a counter finishing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_abort) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LOCK_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_abort) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_BUS_UP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BUS_UP: begin
                if (w_abort) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CORE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (w_abort) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the next state and registered, so all three
    // change on the same edge as the state. Because both resets come from
    // one state value, the core reset can never be low while bus reset is high.
    // ------------------------------------------------------------------
    logic r_rst_bus;
    logic r_rst_core;
    logic r_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rst_bus  <= 1'b1;
            r_rst_core <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_rst_bus  <= (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_HOLD);
            r_rst_core <= (w_state_nxt != S_RUN);
            r_ready    <= (w_state_nxt == S_RUN);
        end
    end

    assign rst_bus_o  = r_rst_bus;
    assign rst_core_o = r_rst_core;
    assign ready_o    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_rst_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_generator
// Purpose  : Self-checking bench for rst_generator with small counts
//            (DEBOUNCE=8, LOCK=4, HOLD=8, CORE_DELAY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_generator;

    localparam int c_DEB  = 8;
    localparam int c_LOCK = 4;
    localparam int c_HOLD = 8;
    localparam int c_CORE = 4;

    logic clk;
    logic rst;
    logic btn;
    logic lock;
    logic rst_bus;
    logic rst_core;
    logic ready;

    int total;
    int bad;
    int ecount;   // rising edges since rst was released

    rst_generator #(
        .DEBOUNCE_CYCLES (c_DEB),
        .LOCK_CYCLES     (c_LOCK),
        .HOLD_CYCLES     (c_HOLD),
        .CORE_DELAY      (c_CORE)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .btn_rst_i    (btn),
        .dcm_locked_i (lock),
        .rst_bus_o    (rst_bus),
        .rst_core_o   (rst_core),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   ed;
        logic btn;
        logic lock;
        logic bus;
        logic core;
        logic rdy;
    } vec_t;

    vec_t pu_tab [10];

    task automatic chk(input string name, input logic eb, input logic ec, input logic er);
        total++;
        if (rst_bus !== eb || rst_core !== ec || ready !== er) begin
            bad++;
            $display("FAIL %s (edge %0d): got bus=%b core=%b ready=%b, want bus=%b core=%b ready=%b",
                     name, ecount, rst_bus, rst_core, ready, eb, ec, er);
        end
    endtask

    // Advance to just after edge n (inputs are changed and outputs sampled
    // 1 ns after the rising edge).
    task automatic edge_to(input int n);
        while (ecount < n) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic do_reset(input logic lock_val);
        rst  = 1'b1;
        btn  = 1'b0;
        lock = lock_val;
        #1;
        chk("reset_async", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_held", 1'b1, 1'b1, 1'b0);
        rst    = 1'b0;
        ecount = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ecount = 0;
        rst  = 1'b1;
        btn  = 1'b0;
        lock = 1'b0;

        // Power-up: lock high, button idle from edge 1.
        pu_tab[0] = '{ed: 0,  btn: 1'b0, lock: 1'b1, bus: 1'b1, core: 1'b1, rdy: 1'b0};
        pu_tab[1] = '{ed: 1,  btn: 1'b0, lock: 1'b1, bus: 1'b1, core: 1'b1, rdy: 1'b0};
        pu_tab[2] = '{ed: 6,  btn: 1'b0, lock: 1'b1, bus: 1'b1, core: 1'b1, rdy: 1'b0};
        pu_tab[3] = '{ed: 13, btn: 1'b0, lock: 1'b1, bus: 1'b1, core: 1'b1, rdy: 1'b0};
        pu_tab[4] = '{ed: 14, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b1, rdy: 1'b0};
        pu_tab[5] = '{ed: 15, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b1, rdy: 1'b0};
        pu_tab[6] = '{ed: 16, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b1, rdy: 1'b0};
        pu_tab[7] = '{ed: 17, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b1, rdy: 1'b0};
        pu_tab[8] = '{ed: 18, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b0, rdy: 1'b1};
        pu_tab[9] = '{ed: 20, btn: 1'b0, lock: 1'b1, bus: 1'b0, core: 1'b0, rdy: 1'b1};

        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            btn  = pu_tab[i].btn;
            lock = pu_tab[i].lock;
            edge_to(pu_tab[i].ed);
            chk($sformatf("powerup_e%0d", pu_tab[i].ed),
                pu_tab[i].bus, pu_tab[i].core, pu_tab[i].rdy);
        end

        // Button glitch of 5 cycles while in RUN: rejected.
        btn = 1'b1;
        edge_to(25);
        btn = 1'b0;
        edge_to(30);
        chk("glitch5_a", 1'b0, 1'b0, 1'b1);
        edge_to(35);
        chk("glitch5_b", 1'b0, 1'b0, 1'b1);

        // Glitch of DEBOUNCE-1 cycles: still rejected.
        edge_to(40);
        btn = 1'b1;
        edge_to(47);
        btn = 1'b0;
        edge_to(50);
        chk("glitch7_a", 1'b0, 1'b0, 1'b1);
        edge_to(55);
        chk("glitch7_b", 1'b0, 1'b0, 1'b1);

        // Held press: changed after edge 60, outputs assert after edge 71.
        edge_to(60);
        btn = 1'b1;
        edge_to(70);
        chk("press_pre", 1'b0, 1'b0, 1'b1);
        edge_to(71);
        chk("press_assert", 1'b1, 1'b1, 1'b0);
        edge_to(80);
        chk("press_held", 1'b1, 1'b1, 1'b0);
        btn = 1'b0;
        // Release after edge 80: bus falls after 80+22, core after 80+26.
        edge_to(101);
        chk("release_bus_pre", 1'b1, 1'b1, 1'b0);
        edge_to(102);
        chk("release_bus", 1'b0, 1'b1, 1'b0);
        edge_to(105);
        chk("release_core_pre", 1'b0, 1'b1, 1'b0);
        edge_to(106);
        chk("release_core", 1'b0, 1'b0, 1'b1);

        // Lock loss in RUN after edge 110: outputs assert after edge 113.
        edge_to(110);
        lock = 1'b0;
        edge_to(112);
        chk("lockloss_pre", 1'b0, 1'b0, 1'b1);
        edge_to(113);
        chk("lockloss", 1'b1, 1'b1, 1'b0);
        edge_to(115);
        lock = 1'b1;
        // Restored after edge 115 behaves like power-up shifted by 115.
        edge_to(128);
        chk("relock_bus_pre", 1'b1, 1'b1, 1'b0);
        edge_to(129);
        chk("relock_bus", 1'b0, 1'b1, 1'b0);
        edge_to(132);
        chk("relock_core_pre", 1'b0, 1'b1, 1'b0);
        edge_to(133);
        chk("relock_core", 1'b0, 1'b0, 1'b1);

        // Lock flicker: lock_sync is low only for the cycle ending at edge 5,
        // which restarts the lock count.
        do_reset(1'b1);
        edge_to(2);
        lock = 1'b0;
        edge_to(3);
        lock = 1'b1;
        edge_to(14);
        chk("flicker_e14", 1'b1, 1'b1, 1'b0);
        edge_to(16);
        chk("flicker_e16", 1'b1, 1'b1, 1'b0);
        edge_to(17);
        chk("flicker_bus", 1'b0, 1'b1, 1'b0);
        edge_to(20);
        chk("flicker_e20", 1'b0, 1'b1, 1'b0);
        edge_to(21);
        chk("flicker_core", 1'b0, 1'b0, 1'b1);

        // Asynchronous rst_i in BUS_UP.
        do_reset(1'b1);
        edge_to(15);
        chk("bus_up", 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midcycle_rst", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
        edge_to(13);
        chk("rerun_e13", 1'b1, 1'b1, 1'b0);
        edge_to(14);
        chk("rerun_bus", 1'b0, 1'b1, 1'b0);
        edge_to(18);
        chk("rerun_core", 1'b0, 1'b0, 1'b1);

        // Random stimulus: bus reset must never be high while core reset is low.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 39) == 0) btn  = ~btn;
            if ($urandom_range(0, 59) == 0) lock = ~lock;
            @(posedge clk);
            #1;
            total++;
            if (rst_bus && !rst_core) begin
                bad++;
                $display("FAIL ordering (cycle %0d): got bus=%b core=%b, want core=1 while bus=1",
                         i, rst_bus, rst_core);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
